// File: rtl/riscv_pkg.sv
// Shared RV32 core types plus the load/store unit's state encoding and lane helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE      = 2'd0,
        MEM_HALF_WORD = 2'd1,
        MEM_WORD      = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_t;

    function automatic logic [3:0] lsu_byte_en(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_BYTE:      return 4'b0001 << offset;
            MEM_HALF_WORD: return 4'b0011 << {offset[1], 1'b0};
            default:       return 4'b1111;
        endcase
    endfunction

    // The unused size encoding is treated like a word so it can never reach the bus unaligned.
    function automatic logic lsu_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_BYTE:      return 1'b0;
            MEM_HALF_WORD: return offset[0];
            default:       return offset != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] lsu_wdata(input mem_size_t size, input logic [31:0] wdata);
        case (size)
            MEM_BYTE:      return {4{wdata[7:0]}};
            MEM_HALF_WORD: return {2{wdata[15:0]}};
            default:       return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/halfword of a raw bus word down to bit 0 and sign- or zero-extends it.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  mem_size_t   size_i,
    input  logic        zext_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        case (size_i)
            MEM_BYTE:      data_o = {{24{~zext_i & shifted[7]}}, shifted[7:0]};
            MEM_HALF_WORD: data_o = {{16{~zext_i & shifted[15]}}, shifted[15:0]};
            default:       data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one outstanding data-memory transaction at a time, stalling the
// pipeline from issue until the access completes.
module lsu_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req_i,
    input  logic        dmem_wr_en_i,
    input  mem_size_t   dmem_size_i,
    input  logic        dmem_zero_extend_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_t  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    mem_size_t   size_q, size_d;
    logic        zext_q, zext_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;

    logic        req_misaligned;
    logic        issue;
    logic [31:0] load_data;

    assign req_misaligned = lsu_misaligned(dmem_size_i, addr_i[1:0]);
    assign issue          = (state_q == LSU_IDLE) && dmem_req_i && !req_misaligned;

    lsu_load_align u_load_align (
        .rdata_i  (bus_rdata_i),
        .size_i   (size_q),
        .zext_i   (zext_q),
        .offset_i (offset_q),
        .data_o   (load_data)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q (or to 0 for pulses) so no branch below infers a latch.
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        size_d        = size_q;
        zext_d        = zext_q;
        offset_d      = offset_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (issue) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = dmem_wr_en_i;
                    bus_addr_d  = {addr_i[31:2], 2'b00};
                    bus_be_d    = lsu_byte_en(dmem_size_i, addr_i[1:0]);
                    bus_wdata_d = lsu_wdata(dmem_size_i, wdata_i);
                    size_d      = dmem_size_i;
                    zext_d      = dmem_zero_extend_i;
                    offset_d    = addr_i[1:0];
                    state_d     = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    state_d   = bus_we_q ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (bus_rvalid_i) begin
                    rdata_d       = load_data;
                    rdata_valid_d = 1'b1;
                    state_d       = LSU_DONE;
                end
            end
            // DONE never looks at dmem_req_i, so the instruction still on the inputs cannot re-issue.
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
        if (rst) begin
            state_q       <= LSU_IDLE;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            size_q        <= MEM_BYTE;
            zext_q        <= 1'b0;
            offset_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            size_q        <= size_d;
            zext_q        <= zext_d;
            offset_q      <= offset_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign stall_o       = issue || (state_q == LSU_REQ) || (state_q == LSU_WAIT);
    assign misaligned_o  = (state_q == LSU_IDLE) && dmem_req_i && req_misaligned;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_be_o      = bus_be_q;
    assign bus_wdata_o   = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses against a
// byte-level reference model of the load/store rules.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmem_req_i, dmem_wr_en_i, dmem_zero_extend_i;
    mem_size_t   dmem_size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, misaligned_o, rdata_valid_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_gnt_i, bus_we_o, bus_rvalid_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] last_rdata;

    lsu_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .dmem_req_i         (dmem_req_i),
        .dmem_wr_en_i       (dmem_wr_en_i),
        .dmem_size_i        (dmem_size_i),
        .dmem_zero_extend_i (dmem_zero_extend_i),
        .addr_i             (addr_i),
        .wdata_i            (wdata_i),
        .stall_o            (stall_o),
        .misaligned_o       (misaligned_o),
        .rdata_o            (rdata_o),
        .rdata_valid_o      (rdata_valid_o),
        .bus_req_o          (bus_req_o),
        .bus_gnt_i          (bus_gnt_i),
        .bus_we_o           (bus_we_o),
        .bus_addr_o         (bus_addr_o),
        .bus_be_o           (bus_be_o),
        .bus_wdata_o        (bus_wdata_o),
        .bus_rvalid_i       (bus_rvalid_i),
        .bus_rdata_i        (bus_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (byte-level view of the access rules) ----------------
    function automatic int nbytes(input mem_size_t sz);
        return (sz == MEM_BYTE) ? 1 : (sz == MEM_HALF_WORD) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input mem_size_t sz, input int off);
        return (off % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input mem_size_t sz, input int off);
        logic [3:0] be = '0;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + nbytes(sz)) be[k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input mem_size_t sz, input logic [31:0] wd);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input mem_size_t sz, input logic zext, input int off,
                                           input logic [31:0] word);
        longint v = 0;
        int     n = nbytes(sz);
        for (int i = 0; i < n; i++) v = v + (longint'(word[8*(off+i) +: 8]) << (8*i));
        if (!zext && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic do_access(input logic we, input mem_size_t sz, input logic zext,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input int gnt_dly, input int rv_dly,
                             output logic [3:0] obs_be, output logic [31:0] obs_wdata,
                             output int obs_stall);
        int          off;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_addr, e_rd;
        int          e_stall;
        off     = int'(addr[1:0]);
        e_be    = m_be(sz, off);
        e_wd    = m_wdata(sz, wd);
        e_addr  = {addr[31:2], 2'b00};
        e_rd    = m_load(sz, zext, off, rword);
        e_stall = 2 + gnt_dly + (we ? 0 : rv_dly + 1);
        obs_stall = 0;
        obs_be    = '0;
        obs_wdata = '0;

        dmem_req_i = 1'b1; dmem_wr_en_i = we; dmem_size_i = sz;
        dmem_zero_extend_i = zext; addr_i = addr; wdata_i = wd;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1 || bus_req_o !== 1'b0 || misaligned_o !== 1'b0) begin
            n_mis++;
            $display("FAIL issue_cycle addr=%h: stall/req/mis=%b%b%b, required 100",
                     addr, stall_o, bus_req_o, misaligned_o);
        end
        if (stall_o) obs_stall++;
        @(posedge clk); #1;

        for (int i = 0; i <= gnt_dly; i++) begin
            bus_gnt_i    = (i == gnt_dly);
            bus_rvalid_i = 1'($urandom_range(0, 1));
            bus_rdata_i  = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, stall_o, rdata_valid_o} !==
                {1'b1, we, e_be, e_addr, e_wd, 1'b1, 1'b0}) begin
                n_mis++;
                $display("FAIL req_phase addr=%h cyc=%0d: req=%b we=%b be=%b a=%h wd=%h stall=%b rv=%b, required 1 %b %b %h %h 1 0",
                         addr, i, bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, stall_o,
                         rdata_valid_o, we, e_be, e_addr, e_wd);
            end
            obs_be    = bus_be_o;
            obs_wdata = bus_wdata_o;
            if (stall_o) obs_stall++;
            @(posedge clk); #1;
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;

        if (!we) begin
            for (int j = 0; j <= rv_dly; j++) begin
                bus_rvalid_i = (j == rv_dly);
                bus_rdata_i  = (j == rv_dly) ? rword : $urandom;
                @(negedge clk);
                n_cmp++;
                if (stall_o !== 1'b1 || bus_req_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
                    n_mis++;
                    $display("FAIL wait_phase addr=%h cyc=%0d: stall/req/rv=%b%b%b, required 100",
                             addr, j, stall_o, bus_req_o, rdata_valid_o);
                end
                if (stall_o) obs_stall++;
                @(posedge clk); #1;
            end
            bus_rvalid_i = 1'b0;
            last_rdata   = e_rd;
        end

        // DONE: dmem_req_i is deliberately still high here
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b0 || bus_req_o !== 1'b0 || rdata_valid_o !== !we || rdata_o !== last_rdata) begin
            n_mis++;
            $display("FAIL done_cycle addr=%h: stall=%b req=%b rv=%b rdata=%h, required 0 0 %b %h",
                     addr, stall_o, bus_req_o, rdata_valid_o, rdata_o, !we, last_rdata);
        end
        if (stall_o) obs_stall++;
        n_cmp++;
        if (obs_stall != e_stall) begin
            n_mis++;
            $display("FAIL stall_count addr=%h: got %0d cycles, required %0d", addr, obs_stall, e_stall);
        end
        @(posedge clk); #1;
        dmem_req_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        n_cmp++;
        if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0 ||
            misaligned_o !== 1'b0 || rdata_o !== last_rdata) begin
            n_mis++;
            $display("FAIL idle_cycle: req=%b stall=%b rv=%b mis=%b rdata=%h, required 0 0 0 0 %h",
                     bus_req_o, stall_o, rdata_valid_o, misaligned_o, rdata_o, last_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic misaligned_access(input logic we, input mem_size_t sz, input logic [31:0] addr);
        dmem_req_i = 1'b1; dmem_wr_en_i = we; dmem_size_i = sz;
        dmem_zero_extend_i = 1'b0; addr_i = addr; wdata_i = $urandom;
        @(negedge clk);
        n_cmp++;
        if (misaligned_o !== 1'b1 || stall_o !== 1'b0 || bus_req_o !== 1'b0) begin
            n_mis++;
            $display("FAIL misaligned addr=%h size=%0d: mis/stall/req=%b%b%b, required 100",
                     addr, sz, misaligned_o, stall_o, bus_req_o);
        end
        @(posedge clk); #1;
        dmem_req_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (misaligned_o !== 1'b0 || bus_req_o !== 1'b0) begin
            n_mis++;
            $display("FAIL misaligned_after addr=%h: mis=%b req=%b, required 0 0",
                     addr, misaligned_o, bus_req_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_req_i = 1'b0; dmem_wr_en_i = 1'b0; dmem_size_i = MEM_BYTE; dmem_zero_extend_i = 1'b0;
        addr_i = '0; wdata_i = '0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        last_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rdata_o, rdata_valid_o,
             misaligned_o, stall_o} !== '0) begin
            n_mis++;
            $display("FAIL reset_state: req=%b we=%b be=%b a=%h wd=%h rd=%h rv=%b mis=%b stall=%b, required all 0",
                     bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o, rdata_o, rdata_valid_o,
                     misaligned_o, stall_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_lw();
        logic [3:0] be; logic [31:0] wd; int st;
        do_access(1'b0, MEM_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, be, wd, st);
        n_cmp++;
        if (be !== 4'hF || st != 3 || rdata_o !== 32'hDEAD_BEEF) begin
            n_mis++;
            $display("FAIL lw_0x100: be=%h stall=%0d rdata=%h, required f 3 deadbeef", be, st, rdata_o);
        end
    endtask

    task automatic test_lb_lbu();
        logic [3:0] be; logic [31:0] wd; int st;
        do_access(1'b0, MEM_BYTE, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0, be, wd, st);
        n_cmp++;
        if (be !== 4'b1000 || rdata_o !== 32'hFFFF_FF80) begin
            n_mis++;
            $display("FAIL lb_0x103: be=%b rdata=%h, required 1000 ffffff80", be, rdata_o);
        end
        idle_cycle();
        do_access(1'b0, MEM_BYTE, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 1, be, wd, st);
        n_cmp++;
        if (rdata_o !== 32'h0000_0080) begin
            n_mis++;
            $display("FAIL lbu_0x103: rdata=%h, required 00000080", rdata_o);
        end
    endtask

    task automatic test_sh_delayed_grant();
        logic [3:0] be; logic [31:0] wd; int st;
        do_access(1'b1, MEM_HALF_WORD, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 0, be, wd, st);
        n_cmp++;
        if (wd !== 32'hABCD_ABCD || be !== 4'b1100 || st != 5) begin
            n_mis++;
            $display("FAIL sh_0x202: wdata=%h be=%b stall=%0d, required abcdabcd 1100 5", wd, be, st);
        end
    endtask

    task automatic test_misaligned();
        misaligned_access(1'b0, MEM_WORD, 32'h0000_0102);
        misaligned_access(1'b0, MEM_HALF_WORD, 32'h0000_0101);
    endtask

    task automatic test_hold_req_through_done();
        logic [3:0] be; logic [31:0] wd; int st;
        do_access(1'b0, MEM_HALF_WORD, 1'b0, 32'h0000_0400, 32'h0, 32'h1357_8642, 1, 2, be, wd, st);
        repeat (2) idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] be; logic [31:0] wd; int st;
        for (int i = 0; i < 6; i++) begin
            mem_size_t sz;
            logic [31:0] a;
            sz = mem_size_t'($urandom_range(0, 2));
            a  = $urandom & ~((32'(nbytes(sz))) - 32'd1);
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2), be, wd, st);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic [3:0] be; logic [31:0] wd; int st;
        for (int i = 0; i < 40; i++) begin
            mem_size_t   sz;
            logic [31:0] a;
            logic        we;
            sz = mem_size_t'($urandom_range(0, 2));
            a  = $urandom;
            we = 1'($urandom_range(0, 1));
            if (m_misaligned(sz, int'(a[1:0])))
                misaligned_access(we, sz, a);
            else begin
                do_access(we, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), be, wd, st);
                if ($urandom_range(0, 1) == 1) idle_cycle();
            end
        end
    endtask

    task automatic test_reset_in_wait();
        dmem_req_i = 1'b1; dmem_wr_en_i = 1'b0; dmem_size_i = MEM_WORD;
        dmem_zero_extend_i = 1'b0; addr_i = 32'h0000_0300; wdata_i = '0;
        @(posedge clk); #1;
        bus_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall_o !== 1'b1 || bus_req_o !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_wait_entry: stall=%b req=%b, required 1 0", stall_o, bus_req_o);
        end
        rst = 1'b1;
        dmem_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        n_cmp++;
        if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0 || rdata_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_wait_after: req=%b stall=%b rdata=%h rv=%b, required 0 0 00000000 0",
                     bus_req_o, stall_o, rdata_o, rdata_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = $urandom | 32'h1;
            @(negedge clk);
            n_cmp++;
            if (rdata_valid_o !== 1'b0 || rdata_o !== 32'h0 || stall_o !== 1'b0) begin
                n_mis++;
                $display("FAIL stray_rvalid cyc=%0d: rv=%b rdata=%h stall=%b, required 0 00000000 0",
                         i, rdata_valid_o, rdata_o, stall_o);
            end
        end
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_delayed_grant();
        test_misaligned();
        test_hold_req_through_done();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the decode/execute stage and the data-memory bus. Turns the decoded memory controls (`dmem_req`, `dmem_wr_en`, `dmem_size`, `dmem_zero_extend`) plus the ALU-computed address into a single-outstanding bus transaction. It generates byte enables and lane-replicated write data, aligns and extends load data, flags misaligned accesses, and stalls the pipeline until the access completes.

## Interface
- Parameters: none. Address and data are fixed at 32 bits (RV32).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `dmem_req_i`  in  1  current instruction is a load/store.
- `dmem_wr_en_i`  in  1  1 = store, 0 = load.
- `dmem_size_i`  in  `mem_size_t`  BYTE / HALF_WORD / WORD.
- `dmem_zero_extend_i`  in  1  load zero-extends (LBU/LHU).
- `addr_i`  in  32  effective address from the ALU.
- `wdata_i`  in  32  store data (rs2).
- `stall_o`  out  1  holds the pipeline (combinational).
- `misaligned_o`  out  1  one-cycle pulse when a misaligned access is detected.
- `rdata_o`  out  32  aligned, extended load result (registered, held).
- `rdata_valid_o`  out  1  `rdata_o` is updated this cycle (DONE state of a load).
- `bus_req_o`  out  1  bus request, registered.
- `bus_gnt_i`  in  1  bus accepts the request this cycle.
- `bus_we_o`  out  1  write request.
- `bus_addr_o`  out  32  word-aligned address (`addr[31:2],2'b00`).
- `bus_be_o`  out  4  byte enables.
- `bus_wdata_o`  out  32  lane-replicated store data.
- `bus_rvalid_i`  in  1  read data valid.
- `bus_rdata_i`  in  32  raw read word.

## Operation
- FSM `lsu_state_t`: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `dmem_req_i` and the access is aligned: latch we/size/zext/`addr[1:0]`, drive the bus registers, go to REQ.
  - If `dmem_req_i` and misaligned (HALF with `addr[0]`=1; WORD with `addr[1:0]`≠0): pulse `misaligned_o`, no bus access, stay IDLE.
- **REQ**
  - `bus_req_o`=1; addr/be/wdata/we stay stable until `bus_gnt_i`.
  - On grant: store → DONE; load → WAIT.
  - `bus_rvalid_i` is ignored in REQ.
- **WAIT**: on `bus_rvalid_i`, register the extracted load value into `rdata_o`, go to DONE.
- **DONE**
  - `stall_o`=0 so the pipeline advances.
  - `rdata_valid_o`=1 for loads.
  - Always go to IDLE next. The still-asserted `dmem_req_i` in DONE is ignored, so the same instruction never re-issues.
- `stall_o` = (IDLE & `dmem_req_i` & aligned) | REQ | WAIT.
- Byte enables:
  - BYTE: `4'b0001 << addr[1:0]`.
  - HALF: `4'b0011 << {addr[1],1'b0}`.
  - WORD: `4'b1111`.
- Write data lanes: BYTE replicates `wdata_i[7:0]` ×4; HALF replicates `wdata_i[15:0]` ×2; WORD passes through.
- Load extraction:
  - Shift `bus_rdata_i` right by `8*addr[1:0]`.
  - Take 8/16/32 bits per size.
  - Sign-extend unless zext=1.
- `rdata_o` holds its last value until the next load completes.

## Timing
- Reset: state=IDLE; `bus_req_o`, `bus_we_o`, `bus_be_o`, `bus_addr_o`, `bus_wdata_o`, `rdata_o`, `rdata_valid_o`, `misaligned_o` all 0.
- Load with immediate grant and next-cycle rvalid: IDLE(c0) → REQ(c1) → WAIT(c2) → DONE(c3).
  - `stall_o` high c0–c2, low c3.
  - `rdata_valid_o` high c3 only.
- Store with immediate grant: IDLE(c0) → REQ(c1) → DONE(c2); stall c0–c1.
- Each extra cycle without grant or rvalid adds one stall cycle; there is no timeout.
- Back-to-back accesses: the next instruction is sampled in IDLE the cycle after DONE (minimum 1 idle cycle between bus requests).
- Reset mid-operation (REQ/WAIT): IDLE at the next edge and `bus_req_o` drops. An rvalid arriving later is ignored.
- `misaligned_o` is combinational in IDLE and high for exactly one cycle per offending instruction. The pipeline, not this block, removes the instruction.

## Structure
- `riscv_pkg` gets `lsu_state_t`.
- `riscv_pkg` also gets the functions `lsu_byte_en(mem_size_t, logic[1:0])` and `lsu_misaligned(mem_size_t, logic[1:0])`.
- `mem_size_t` is reused unchanged.
- Sub-module `lsu_load_align`: combinational shift/extract/extend of `bus_rdata_i` from size, zext and offset. It is instantiated once.

## Test plan
- LW addr 0x100, grant immediate, rvalid next cycle with 0xDEADBEEF:
  - `bus_be_o`=4'hF, `bus_addr_o`=0x100.
  - `rdata_o`=0xDEADBEEF at c3.
  - stall exactly 3 cycles.
- LB addr 0x103, rdata 0x80FF_0000 → be=4'b1000, `rdata_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, grant delayed 3 cycles:
  - bus_wdata=0xABCDABCD, be=4'b1100, `bus_we_o`=1.
  - addr/be/wdata stable across the wait; stall 5 cycles.
- LW at 0x102 and LH at 0x101: `misaligned_o` one-cycle pulse, `bus_req_o` stays 0, `stall_o`=0.
- Reset asserted in WAIT, then stray rvalid: `bus_req_o`=0 the next cycle; `rdata_o`=0; `rdata_valid_o` never rises.
- `dmem_req_i` held high through DONE for one load: exactly one bus request is issued.
